// File: rtl/fsm_door_gen2.sv
// fsm_door_gen2: garage-door controller with travel timeout, auto-close, reversal dead time and latched fault
module fsm_door_gen2 #(
  parameter int TMR_W      = 16,
  parameter int TRAVEL_MAX = 1000,
  parameter int AUTOCLOSE  = 4000,
  parameter int DEAD_CYC   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       sense_up,
  input  logic       sense_down,
  input  logic       obstruct,
  input  logic       fault_clr,
  output logic       mr,
  output logic       ml,
  output logic       light_red,
  output logic       light_green,
  output logic       fault,
  output logic [2:0] db_state
);
  typedef enum logic [2:0] {
    STOP   = 3'b000,
    CLOSED = 3'b001,
    OPEN   = 3'b010,
    UP     = 3'b011,
    DOWN   = 3'b100,
    FAULT  = 3'b101
  } state_t;
  localparam int DW = DEAD_CYC > 1 ? $clog2(DEAD_CYC + 1) : 1;
  localparam logic [TMR_W-1:0] T_LAST = TMR_W'(TRAVEL_MAX - 1);
  localparam logic [TMR_W-1:0] A_LAST = TMR_W'(AUTOCLOSE > 0 ? AUTOCLOSE - 1 : 0);
  localparam logic [DW-1:0] D_LOAD = DW'(DEAD_CYC);
  state_t state, nxt;
  logic [TMR_W-1:0] tmr, nxt_tmr;
  logic [DW-1:0] dead, nxt_dead;
  logic rev;
  // next state: fault latch, dual-sensor fault and emergency stop override the per-state moves
  always_comb begin
    nxt = state;
    if (state == FAULT) nxt = fault_clr ? STOP : FAULT;
    else if (sense_up && sense_down) nxt = FAULT;
    else if (key_up && key_down) nxt = STOP;
    else
      case (state)
        STOP:    nxt = key_up ? UP : key_down ? DOWN : sense_down ? CLOSED : sense_up ? OPEN : STOP;
        CLOSED:  nxt = key_up ? UP : CLOSED;
        OPEN:    nxt = (key_down || (AUTOCLOSE != 0 && tmr == A_LAST)) ? DOWN : OPEN;
        UP:      nxt = sense_up ? OPEN : key_down ? DOWN : tmr == T_LAST ? FAULT : UP;
        DOWN:    nxt = sense_down ? CLOSED : (key_up || obstruct) ? UP : tmr == T_LAST ? FAULT : DOWN;
        default: nxt = STOP;
      endcase
  end
  // shared timer restarts on every state change (and on key_up while open); dead time only on direct reversal
  always_comb begin
    rev = (state == UP && nxt == DOWN) || (state == DOWN && nxt == UP);
    nxt_tmr = (nxt != state || (state == OPEN && key_up)) ? '0 :
              ((state == UP || state == DOWN || state == OPEN) && tmr != '1) ? tmr + TMR_W'(1) : tmr;
    nxt_dead = rev ? D_LOAD : nxt != state ? '0 : dead != '0 ? dead - DW'(1) : dead;
  end
  // state, timers and outputs registered together so outputs decode the new state with no glitches
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= STOP;
      tmr         <= '0;
      dead        <= '0;
      mr          <= 1'b0;
      ml          <= 1'b0;
      light_red   <= 1'b1;
      light_green <= 1'b0;
      fault       <= 1'b0;
      db_state    <= 3'b000;
    end else begin
      state       <= nxt;
      tmr         <= nxt_tmr;
      dead        <= nxt_dead;
      mr          <= nxt == UP && nxt_dead == '0;
      ml          <= nxt == DOWN && nxt_dead == '0;
      light_red   <= nxt != OPEN;
      light_green <= nxt == OPEN;
      fault       <= nxt == FAULT;
      db_state    <= nxt;
    end
  end
endmodule

// File: tb/tb_fsm_door_gen2.sv
// tb_fsm_door_gen2: directed scenario tests for the door controller
module tb_fsm_door_gen2;
  logic clk = 1'b0, rst_n = 1'b0;
  logic key_up = 1'b0, key_down = 1'b0, sense_up = 1'b0, sense_down = 1'b0, obstruct = 1'b0, fault_clr = 1'b0;
  logic mr, ml, light_red, light_green, fault;
  logic [2:0] db_state;
  int vecs = 0, errs = 0;
  logic [7:0] obs;
  // {mr, ml, red, green, fault, db_state}
  localparam logic [7:0] O_STOP   = 8'b0010_0000;
  localparam logic [7:0] O_CLOSED = 8'b0010_0001;
  localparam logic [7:0] O_OPEN   = 8'b0001_0010;
  localparam logic [7:0] O_UPRUN  = 8'b1010_0011;
  localparam logic [7:0] O_UPDEAD = 8'b0010_0011;
  localparam logic [7:0] O_DNRUN  = 8'b0110_0100;
  localparam logic [7:0] O_DNDEAD = 8'b0010_0100;
  localparam logic [7:0] O_FAULT  = 8'b0010_1101;
  assign obs = {mr, ml, light_red, light_green, fault, db_state};
  fsm_door_gen2 #(.TMR_W(16), .TRAVEL_MAX(8), .AUTOCLOSE(12), .DEAD_CYC(2)) dut (
    .clk(clk), .rst_n(rst_n), .key_up(key_up), .key_down(key_down), .sense_up(sense_up),
    .sense_down(sense_down), .obstruct(obstruct), .fault_clr(fault_clr), .mr(mr), .ml(ml),
    .light_red(light_red), .light_green(light_green), .fault(fault), .db_state(db_state)
  );
  always #5 clk = ~clk;
  // both motors must never run together
  always @(negedge clk)
    if (mr === 1'b1 && ml === 1'b1) begin
      errs++;
      $display("FAIL motor_exclusive: mr=%b ml=%b both on", mr, ml);
    end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst_n = 1'b0; sense_down = 1'b1;
    step(); step();
    vecs++; if (obs !== O_STOP) begin errs++; $display("FAIL reset_stop: got %b want %b", obs, O_STOP); end
    rst_n = 1'b1;
    step();
    vecs++; if (obs !== O_CLOSED) begin errs++; $display("FAIL reset_closed: got %b want %b", obs, O_CLOSED); end
  endtask
  task automatic test_open();
    key_down = 1'b1;
    step();
    vecs++; if (obs !== O_CLOSED) begin errs++; $display("FAIL closed_keydown_ignored: got %b want %b", obs, O_CLOSED); end
    key_down = 1'b0; key_up = 1'b1;
    step();
    vecs++; if (obs !== O_UPRUN) begin errs++; $display("FAIL open_up: got %b want %b", obs, O_UPRUN); end
    key_up = 1'b0; sense_down = 1'b0;
    repeat (3) step();
    vecs++; if (obs !== O_UPRUN) begin errs++; $display("FAIL open_travel: got %b want %b", obs, O_UPRUN); end
    sense_up = 1'b1;
    step();
    vecs++; if (obs !== O_OPEN) begin errs++; $display("FAIL open_reached: got %b want %b", obs, O_OPEN); end
  endtask
  task automatic test_autoclose();
    repeat (11) step();
    vecs++; if (obs !== O_OPEN) begin errs++; $display("FAIL autoclose_minus1: got %b want %b", obs, O_OPEN); end
    sense_up = 1'b0;
    step();
    vecs++; if (obs !== O_DNRUN) begin errs++; $display("FAIL autoclose_fire: got %b want %b", obs, O_DNRUN); end
    obstruct = 1'b1;
    step();
    vecs++; if (obs !== O_UPDEAD) begin errs++; $display("FAIL obstruct_dead1: got %b want %b", obs, O_UPDEAD); end
    obstruct = 1'b0;
    step();
    vecs++; if (obs !== O_UPDEAD) begin errs++; $display("FAIL obstruct_dead2: got %b want %b", obs, O_UPDEAD); end
    step();
    vecs++; if (obs !== O_UPRUN) begin errs++; $display("FAIL obstruct_run: got %b want %b", obs, O_UPRUN); end
  endtask
  task automatic test_timeout();
    repeat (5) step();
    vecs++; if (obs !== O_UPRUN) begin errs++; $display("FAIL timeout_minus1: got %b want %b", obs, O_UPRUN); end
    step();
    vecs++; if (obs !== O_FAULT) begin errs++; $display("FAIL timeout_fault: got %b want %b", obs, O_FAULT); end
    key_up = 1'b1; key_down = 1'b1; sense_up = 1'b1; sense_down = 1'b1;
    step();
    vecs++; if (obs !== O_FAULT) begin errs++; $display("FAIL fault_inputs_ignored: got %b want %b", obs, O_FAULT); end
    key_up = 1'b0; key_down = 1'b0; sense_up = 1'b0; sense_down = 1'b0; fault_clr = 1'b1;
    step();
    vecs++; if (obs !== O_STOP) begin errs++; $display("FAIL fault_clear: got %b want %b", obs, O_STOP); end
    fault_clr = 1'b0;
  endtask
  task automatic test_estop();
    key_down = 1'b1;
    step();
    vecs++; if (obs !== O_DNRUN) begin errs++; $display("FAIL estop_down: got %b want %b", obs, O_DNRUN); end
    key_up = 1'b1;
    step();
    vecs++; if (obs !== O_STOP) begin errs++; $display("FAIL estop: got %b want %b", obs, O_STOP); end
    key_up = 1'b0;
    step();
    vecs++; if (obs !== O_DNRUN) begin errs++; $display("FAIL estop_resume: got %b want %b", obs, O_DNRUN); end
    key_down = 1'b0;
  endtask
  task automatic test_reversal();
    key_up = 1'b1;
    step();
    vecs++; if (obs !== O_UPDEAD) begin errs++; $display("FAIL rev_up_dead1: got %b want %b", obs, O_UPDEAD); end
    key_up = 1'b0;
    step();
    vecs++; if (obs !== O_UPDEAD) begin errs++; $display("FAIL rev_up_dead2: got %b want %b", obs, O_UPDEAD); end
    step();
    vecs++; if (obs !== O_UPRUN) begin errs++; $display("FAIL rev_up_run: got %b want %b", obs, O_UPRUN); end
    key_down = 1'b1;
    step();
    vecs++; if (obs !== O_DNDEAD) begin errs++; $display("FAIL rev_down_dead: got %b want %b", obs, O_DNDEAD); end
    key_down = 1'b0; sense_down = 1'b1;
    step();
    vecs++; if (obs !== O_CLOSED) begin errs++; $display("FAIL rev_closed: got %b want %b", obs, O_CLOSED); end
  endtask
  task automatic test_autoclose_restart();
    key_up = 1'b1;
    step();
    key_up = 1'b0; sense_down = 1'b0; sense_up = 1'b1;
    step();
    vecs++; if (obs !== O_OPEN) begin errs++; $display("FAIL restart_open: got %b want %b", obs, O_OPEN); end
    repeat (10) step();
    key_up = 1'b1;
    step();
    key_up = 1'b0;
    vecs++; if (obs !== O_OPEN) begin errs++; $display("FAIL restart_clear: got %b want %b", obs, O_OPEN); end
    repeat (11) step();
    vecs++; if (obs !== O_OPEN) begin errs++; $display("FAIL restart_minus1: got %b want %b", obs, O_OPEN); end
    sense_up = 1'b0;
    step();
    vecs++; if (obs !== O_DNRUN) begin errs++; $display("FAIL restart_fire: got %b want %b", obs, O_DNRUN); end
  endtask
  task automatic test_both_sensors();
    sense_down = 1'b1;
    step();
    key_up = 1'b1;
    step();
    key_up = 1'b0; sense_down = 1'b0; sense_up = 1'b1;
    step();
    vecs++; if (obs !== O_OPEN) begin errs++; $display("FAIL both_pre_open: got %b want %b", obs, O_OPEN); end
    sense_down = 1'b1;
    step();
    vecs++; if (obs !== O_FAULT) begin errs++; $display("FAIL both_sensors: got %b want %b", obs, O_FAULT); end
    sense_up = 1'b0; sense_down = 1'b0; fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    vecs++; if (obs !== O_STOP) begin errs++; $display("FAIL both_clear: got %b want %b", obs, O_STOP); end
  endtask
  task automatic test_reset_travel();
    key_up = 1'b1;
    step();
    key_up = 1'b0;
    step();
    vecs++; if (obs !== O_UPRUN) begin errs++; $display("FAIL travel_up: got %b want %b", obs, O_UPRUN); end
    rst_n = 1'b0;
    step();
    vecs++; if (obs !== O_STOP) begin errs++; $display("FAIL reset_mid_travel: got %b want %b", obs, O_STOP); end
    rst_n = 1'b1;
    step();
    vecs++; if (obs !== O_STOP) begin errs++; $display("FAIL post_reset_idle: got %b want %b", obs, O_STOP); end
  endtask
  initial begin
    test_reset();
    test_open();
    test_autoclose();
    test_timeout();
    test_estop();
    test_reversal();
    test_autoclose_restart();
    test_both_sensors();
    test_reset_travel();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
